// File: rtl/toothless_pkg.sv
// Shared load/store unit types: access sizes, FSM states and small helpers
// for size normalisation and natural-alignment masking.
package toothless_pkg;

    typedef enum logic [1:0] {
        DATA_TYPE_BYTE = 2'b00,
        DATA_TYPE_HALF = 2'b01,
        DATA_TYPE_WORD = 2'b10
    } lsu_data_type_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        DONE
    } lsu_state_e;

    // The unused 2'b11 encoding behaves as a word access.
    function automatic lsu_data_type_e lsu_norm_type(input logic [1:0] raw);
        case (raw)
            2'b00:   return DATA_TYPE_BYTE;
            2'b01:   return DATA_TYPE_HALF;
            default: return DATA_TYPE_WORD;
        endcase
    endfunction

    function automatic logic [1:0] lsu_align_off(input lsu_data_type_e t, input logic [1:0] off);
        case (t)
            DATA_TYPE_BYTE: return off;
            DATA_TYPE_HALF: return {off[1], 1'b0};
            default:        return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: store byte enables and replicated
// write data, plus load lane extraction with sign/zero extension.
module lsu_align
    import toothless_pkg::*;
(
    input  lsu_data_type_e st_type_i,
    input  logic [1:0]     st_off_i,
    input  logic [31:0]    wdata_i,
    output logic [3:0]     be_o,
    output logic [31:0]    wdata_o,
    input  lsu_data_type_e ld_type_i,
    input  logic [1:0]     ld_off_i,
    input  logic           ld_sign_ext_i,
    input  logic [31:0]    rdata_i,
    output logic [31:0]    rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (st_type_i)
            DATA_TYPE_BYTE: begin
                be_o    = 4'b0001 << st_off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            DATA_TYPE_HALF: begin
                be_o    = 4'b0011 << {st_off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_lane = rdata_i[7:0];
        case (ld_off_i)
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            2'd3:    byte_lane = rdata_i[31:24];
            default: byte_lane = rdata_i[7:0];
        endcase
        half_lane = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        rdata_o   = rdata_i;
        case (ld_type_i)
            DATA_TYPE_BYTE: rdata_o = {{24{ld_sign_ext_i & byte_lane[7]}}, byte_lane};
            DATA_TYPE_HALF: rdata_o = {{16{ld_sign_ext_i & half_lane[15]}}, half_lane};
            default:        rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: one req/gnt/rvalid transaction per access.
// Optional LSU_MISALIGNED_TRAP_EN traps misaligned half/word accesses locally.
module load_store_unit
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [1:0]            data_type_i,
    input  logic                  data_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  misaligned_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i
);

    lsu_state_e            state_q, state_d;
    logic                  we_q, sext_q;
    lsu_data_type_e        type_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    lsu_data_type_e        req_type;
    logic [1:0]            req_off;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata, rdata_ext;
    logic                  accept, misal;

    assign req_type = lsu_norm_type(data_type_i);
    assign req_off  = lsu_align_off(req_type, addr_i[1:0]);
    assign accept   = (state_q == IDLE) && data_req_i;

    lsu_align u_align (
        .st_type_i     (req_type),
        .st_off_i      (req_off),
        .wdata_i       (wdata_i),
        .be_o          (req_be),
        .wdata_o       (req_wdata),
        .ld_type_i     (type_q),
        .ld_off_i      (off_q),
        .ld_sign_ext_i (sext_q),
        .rdata_i       (mem_rdata_i),
        .rdata_o       (rdata_ext)
    );

`ifdef LSU_MISALIGNED_TRAP_EN
    logic mis_q;
    assign misal = ((req_type == DATA_TYPE_HALF) && addr_i[0]) ||
                   ((req_type == DATA_TYPE_WORD) && (addr_i[1:0] != 2'b00));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mis_q <= 1'b0;
        else if (accept) mis_q <= misal;
    end
    assign misaligned_o = valid_o & mis_q;
`else
    assign misal        = 1'b0;
    assign misaligned_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    if (misal) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: if (mem_gnt_i) state_d = WAIT_RVALID;
            WAIT_RVALID: begin
                if (mem_rvalid_i) begin
                    state_d = DONE;
                    err_d   = mem_err_i;
                    // Store completions must not disturb the last load result.
                    if (!we_q) rdata_d = rdata_ext;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            type_q  <= DATA_TYPE_BYTE;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= data_we_i;
                sext_q  <= data_sign_ext_i;
                type_q  <= req_type;
                off_q   <= req_off;
                addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
        end
    end

    assign valid_o     = (state_q == DONE);
    assign stall_o     = accept || (state_q == WAIT_GNT) || (state_q == WAIT_RVALID);
    assign err_o       = valid_o & err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = (state_q == WAIT_GNT);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised self-checking bench for load_store_unit with an abstract
// arithmetic reference model and a scripted memory responder.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        data_req_i, data_we_i, data_sign_ext_i;
    logic [1:0]  data_type_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, valid_o, err_o, misaligned_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i, mem_err_i;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_rdata = 32'h0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_req_i      (data_req_i),
        .data_we_i       (data_we_i),
        .data_type_i     (data_type_i),
        .data_sign_ext_i (data_sign_ext_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .stall_o         (stall_o),
        .valid_o         (valid_o),
        .rdata_o         (rdata_o),
        .err_o           (err_o),
        .misaligned_o    (misaligned_o),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .mem_err_i       (mem_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_mis"}, misaligned_o, 0);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_req"}, mem_req_o, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_we"}, mem_we_o, 0);
        chk({tag, "_be"}, mem_be_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
    endtask

    // One complete access: gd extra cycles before gnt, rd extra cycles before rvalid.
    task automatic access(input bit we, input bit [1:0] dt, input bit sx, input bit [31:0] addr,
                          input bit [31:0] wd, input bit [31:0] raw, input bit berr,
                          input int gd, input int rd);
        int          size;
        int          off, hoff;
        bit [31:0]   lane, eld, ewd, eaddr;
        bit [3:0]    ebe;
        bit          mis;
        size  = (dt == 2'd3) ? 2 : int'(dt);
        off   = int'(addr[1:0]);
        hoff  = int'(addr[1]);
        eaddr = addr & 32'hFFFF_FFFC;
        if (size == 0) begin
            ebe  = 4'(1 << off);
            ewd  = (wd & 32'hFF) * 32'h0101_0101;
            lane = (raw >> (8 * off)) & 32'hFF;
            eld  = (sx && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
        end else if (size == 1) begin
            ebe  = 4'(3 << (2 * hoff));
            ewd  = (wd & 32'hFFFF) * 32'h0001_0001;
            lane = (raw >> (16 * hoff)) & 32'hFFFF;
            eld  = (sx && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
        end else begin
            ebe = 4'hF;
            ewd = wd;
            eld = raw;
        end
        mis = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);

        @(posedge clk); #1;
        data_req_i = 1'b1; data_we_i = we; data_type_i = dt;
        data_sign_ext_i = sx; addr_i = addr; wdata_i = wd;
        @(negedge clk);
        chk("stall_accept", stall_o, 1);
        chk("req_accept", mem_req_o, 0);
        chk("valid_accept", valid_o, 0);

`ifdef LSU_MISALIGNED_TRAP_EN
        if (mis) begin
            @(posedge clk); #1;
            addr_i = $urandom; wdata_i = $urandom;
            @(negedge clk);
            chk("trap_valid", valid_o, 1);
            chk("trap_err", err_o, 1);
            chk("trap_mis", misaligned_o, 1);
            chk("trap_req", mem_req_o, 0);
            chk("trap_stall", stall_o, 0);
            chk("trap_rdata", rdata_o, exp_rdata);
            data_req_i = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk("trap_valid_pulse", valid_o, 0);
            chk("trap_req_after", mem_req_o, 0);
            return;
        end
`endif

        for (int k = 0; k <= gd; k++) begin
            @(posedge clk); #1;
            mem_gnt_i = (k == gd);
            // Controller inputs may wander; the request must stay latched.
            addr_i = $urandom; wdata_i = $urandom; data_type_i = 2'($urandom);
            @(negedge clk);
            chk("gnt_req", mem_req_o, 1);
            chk("gnt_addr", mem_addr_o, eaddr);
            chk("gnt_be", mem_be_o, ebe);
            chk("gnt_we", mem_we_o, we);
            chk("gnt_wdata", mem_wdata_o, ewd);
            chk("gnt_stall", stall_o, 1);
            chk("gnt_valid", valid_o, 0);
        end
        for (int k = 0; k <= rd; k++) begin
            @(posedge clk); #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = (k == rd);
            mem_rdata_i  = (k == rd) ? raw : $urandom;
            mem_err_i    = (k == rd) ? berr : 1'b0;
            @(negedge clk);
            chk("rv_req", mem_req_o, 0);
            chk("rv_stall", stall_o, 1);
            chk("rv_valid", valid_o, 0);
        end
        @(posedge clk); #1;
        mem_rvalid_i = 1'($urandom); mem_gnt_i = 1'($urandom);
        mem_rdata_i  = $urandom;     mem_err_i = 1'($urandom);
        if (!we) exp_rdata = eld;
        @(negedge clk);
        chk("done_valid", valid_o, 1);
        chk("done_stall", stall_o, 0);
        chk("done_err", err_o, berr);
        chk("done_mis", misaligned_o, 0);
        chk("done_rdata", rdata_o, exp_rdata);
        data_req_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_valid", valid_o, 0);
        chk("idle_req", mem_req_o, 0);
        chk("idle_stall", stall_o, 0);
        chk("idle_rdata", rdata_o, exp_rdata);
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; mem_err_i = 1'b0;
    endtask

    task automatic reset_mid_access();
        @(posedge clk); #1;
        data_req_i = 1'b1; data_we_i = 1'b0; data_type_i = 2'd2;
        data_sign_ext_i = 1'b0; addr_i = 32'h300; wdata_i = 32'h0;
        @(posedge clk); #1;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk("rst_pre_stall", stall_o, 1);
        chk("rst_pre_req", mem_req_o, 0);
        @(posedge clk); #2;
        data_req_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D; mem_err_i = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_late");
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; mem_err_i = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_after");
    endtask

    initial begin
        rst_n = 1'b0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_type_i = 2'd0; data_sign_ext_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        access(0, 2'd2, 0, 32'h100, 32'h0,      32'hDEAD_BEEF, 0, 0, 0);
        access(0, 2'd0, 1, 32'h103, 32'h0,      32'h8000_0000, 0, 0, 0);
        access(0, 2'd0, 0, 32'h103, 32'h0,      32'h8000_0000, 0, 0, 0);
        access(1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 32'h0,      0, 3, 0);
        access(0, 2'd2, 0, 32'h100, 32'h0,      32'h1111_2222, 1, 0, 1);
        access(0, 2'd2, 0, 32'h101, 32'h0,      32'h7654_3210, 0, 1, 0);
        access(0, 2'd1, 1, 32'h107, 32'h0,      32'h8001_7FFF, 0, 0, 2);
        reset_mid_access();

        for (int i = 0; i < 150; i++) begin
            access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
